dmem_arbiter: RTL and testbench

Shares the single data-memory port between two requesters: port 0, the CPU memory-access stage, and port 1, the program loader/debug port. Each requester sees a req/ack handshake. Grant is round-robin. The memory is modelled with a fixed read latency of WAIT_STATES cycles. The block sits between the CPU memory stage and the top-level dmem_* pins, and the CPU stalls on `p0_ack`.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter_rr_pick2.sv | 26 ++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared types and default sizes for the data-memory arbiter.
//   DMEM_* values are the default data-memory geometry and memory read latency.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_WIDTH  = 8;
  localparam int DMEM_DATA_WIDTH  = 16;
  localparam int DMEM_WAIT_STATES = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  // Port index (0 = CPU, 1 = loader/debug) to one-hot grant vector.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles both requester handshakes, the status outputs and the memory pins.
//   slave  : the arbiter side (takes requests and read data, drives acks/memory).
//   master : the environment side (requesters plus memory).
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH
) ();

  logic                  p0_req;
  logic                  p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_ack;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_ack;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic                  busy;
  logic [1:0]            grant;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wenable;
  logic [DATA_WIDTH-1:0] mem_wvalue;
  logic [DATA_WIDTH-1:0] mem_rvalue;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rvalue,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output busy, grant,
    output mem_addr, mem_wenable, mem_wvalue
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rvalue,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  busy, grant,
    input  mem_addr, mem_wenable, mem_wvalue
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational two-way round-robin picker.
//   req[1:0] : pending requests
//   last     : index of the port granted most recently
//   win[1:0] : one-hot winner (00 when nothing requested)
//   valid    : at least one request pending
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win,
  output logic       valid
);

  always_comb begin
    win   = 2'b00;
    valid = |req;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      // Tie goes to whichever port was not served last.
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data-memory port between the CPU memory stage (port 0) and the
//   loader/debug port (port 1) with round-robin grant and a fixed read latency.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : both req/ack handshakes, busy/grant status, memory pins
//
//   state  | meaning
//   IDLE   | no transaction; grants a pending request
//   ACCESS | memory cycle(s) for the latched request; last one strobes/captures
//   DONE   | one-cycle ack to the owner, then back to IDLE
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DMEM_DATA_WIDTH,
  parameter int WAIT_STATES = DMEM_WAIT_STATES
) (
  input logic           clock,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  arb_state_t            state_q, state_d;
  logic [3:0]            cnt_q;
  logic                  owner_q;
  logic                  last_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  logic [1:0] win;
  logic       req_valid;
  logic       take_grant;
  logic       final_access;

  rr_pick2 u_pick (
    .req   ({bus.p1_req, bus.p0_req}),
    .last  (last_q),
    .win   (win),
    .valid (req_valid)
  );

  assign take_grant   = (state_q == IDLE) && req_valid;
  assign final_access = (state_q == ACCESS) && (cnt_q == 4'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.busy        = 1'b0;
    bus.grant       = 2'b00;
    bus.mem_wenable = 1'b0;
    bus.p0_ack      = 1'b0;
    bus.p1_ack      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) state_d = ACCESS;
      end
      ACCESS: begin
        bus.busy        = 1'b1;
        bus.grant       = port_onehot(owner_q);
        bus.mem_wenable = final_access && we_q;
        if (cnt_q == 4'd0) state_d = DONE;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.grant  = port_onehot(owner_q);
        bus.p0_ack = !owner_q;
        bus.p1_ack = owner_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= 4'd0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (take_grant) begin
        owner_q <= win[1];
        last_q  <= win[1];
        we_q    <= win[1] ? bus.p1_we    : bus.p0_we;
        addr_q  <= win[1] ? bus.p1_addr  : bus.p0_addr;
        wdata_q <= win[1] ? bus.p1_wdata : bus.p0_wdata;
        cnt_q   <= WS;
      end else if ((state_q == ACCESS) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (final_access && !we_q) begin
        if (owner_q) rdata1_q <= bus.mem_rvalue;
        else         rdata0_q <= bus.mem_rvalue;
      end
    end
  end

  // Memory address/data come straight from the latches, so they hold their
  // last values through DONE and IDLE.
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wvalue = wdata_q;
  assign bus.p0_rdata   = rdata0_q;
  assign bus.p1_rdata   = rdata1_q;

  // The owner must keep its request up until it has been acknowledged.
  a_req_held: assert property (
    @(posedge clock) disable iff (reset)
    (state_q == ACCESS) |-> (owner_q ? bus.p1_req : bus.p0_req)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter: WAIT_STATES=1 instance for the main
//   sequences, plus WAIT_STATES=0 and WAIT_STATES=15 instances for latency.
module tb_dmem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus1 ();
  dmem_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus0 ();
  dmem_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus15 ();

  dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(1))
    u_dut1 (.clock(clock), .reset(reset), .bus(bus1));
  dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(0))
    u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
  dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(15))
    u_dut15 (.clock(clock), .reset(reset), .bus(bus15));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected grant per cycle for the four back-to-back tie transactions
  // (1 = p0, 2 = p1, 0 = idle).
  int gtab [16] = '{1, 1, 1, 0, 2, 2, 2, 0, 1, 1, 1, 0, 2, 2, 2, 0};

  initial begin
    bus0.p0_req = 0; bus0.p0_we = 0; bus0.p0_addr = 0; bus0.p0_wdata = 0;
    bus0.p1_req = 0; bus0.p1_we = 0; bus0.p1_addr = 0; bus0.p1_wdata = 0;
    bus0.mem_rvalue = 0;
    bus15.p0_req = 0; bus15.p0_we = 0; bus15.p0_addr = 0; bus15.p0_wdata = 0;
    bus15.p1_req = 0; bus15.p1_we = 0; bus15.p1_addr = 0; bus15.p1_wdata = 0;
    bus15.mem_rvalue = 0;

    // Reset held with random inputs on the main instance.
    for (int i = 0; i < 4; i++) begin
      bus1.p0_req = 1'($urandom); bus1.p0_we = 1'($urandom);
      bus1.p0_addr = 8'($urandom); bus1.p0_wdata = 16'($urandom);
      bus1.p1_req = 1'($urandom); bus1.p1_we = 1'($urandom);
      bus1.p1_addr = 8'($urandom); bus1.p1_wdata = 16'($urandom);
      bus1.mem_rvalue = 16'($urandom);
      tick();
    end
    check_val("rst busy", 32'(bus1.busy), 0);
    check_val("rst grant", 32'(bus1.grant), 0);
    check_val("rst p0_ack", 32'(bus1.p0_ack), 0);
    check_val("rst p1_ack", 32'(bus1.p1_ack), 0);
    check_val("rst p0_rdata", 32'(bus1.p0_rdata), 0);
    check_val("rst p1_rdata", 32'(bus1.p1_rdata), 0);
    check_val("rst mem_addr", 32'(bus1.mem_addr), 0);
    check_val("rst mem_wenable", 32'(bus1.mem_wenable), 0);
    check_val("rst mem_wvalue", 32'(bus1.mem_wvalue), 0);

    bus1.p0_req = 0; bus1.p1_req = 0;
    bus1.p0_we = 0; bus1.p1_we = 0;
    reset = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_val($sformatf("idle busy c%0d", c), 32'(bus1.busy), 0);
      check_val($sformatf("idle grant c%0d", c), 32'(bus1.grant), 0);
    end

    // p0 read of 0x12, memory returns 0xBEEF.
    bus1.mem_rvalue = 16'hBEEF;
    bus1.p0_we = 0; bus1.p0_addr = 8'h12; bus1.p0_req = 1;
    check_val("rd c0 grant", 32'(bus1.grant), 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_val($sformatf("rd c%0d p0_ack", c), 32'(bus1.p0_ack), (c == 3) ? 1 : 0);
      check_val($sformatf("rd c%0d wen", c), 32'(bus1.mem_wenable), 0);
      check_val($sformatf("rd c%0d busy", c), 32'(bus1.busy), (c <= 3) ? 1 : 0);
      check_val($sformatf("rd c%0d grant", c), 32'(bus1.grant), (c <= 3) ? 1 : 0);
      if (c <= 2) check_val($sformatf("rd c%0d addr", c), 32'(bus1.mem_addr), 32'h12);
      if (c >= 3) check_val($sformatf("rd c%0d p0_rdata", c), 32'(bus1.p0_rdata), 32'hBEEF);
      if (c == 3) bus1.p0_req = 0;
    end

    // p1 read of 0x31 returning 0x1234; p0_rdata must be untouched.
    bus1.mem_rvalue = 16'h1234;
    bus1.p1_we = 0; bus1.p1_addr = 8'h31; bus1.p1_req = 1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_val($sformatf("rd1 c%0d p1_ack", c), 32'(bus1.p1_ack), (c == 3) ? 1 : 0);
      check_val($sformatf("rd1 c%0d p0_ack", c), 32'(bus1.p0_ack), 0);
    end
    check_val("rd1 p1_rdata", 32'(bus1.p1_rdata), 32'h1234);
    check_val("rd1 p0_rdata", 32'(bus1.p0_rdata), 32'hBEEF);
    bus1.p1_req = 0;
    tick();

    // p1 write of 0x5A5A to 0x30; memory drives junk that must not be captured.
    bus1.mem_rvalue = 16'hDEAD;
    bus1.p1_we = 1; bus1.p1_addr = 8'h30; bus1.p1_wdata = 16'h5A5A; bus1.p1_req = 1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_val($sformatf("wr c%0d wen", c), 32'(bus1.mem_wenable), (c == 2) ? 1 : 0);
      check_val($sformatf("wr c%0d p1_ack", c), 32'(bus1.p1_ack), (c == 3) ? 1 : 0);
      if (c <= 3) check_val($sformatf("wr c%0d grant", c), 32'(bus1.grant), 2);
      if (c == 2) begin
        check_val("wr c2 addr", 32'(bus1.mem_addr), 32'h30);
        check_val("wr c2 wvalue", 32'(bus1.mem_wvalue), 32'h5A5A);
      end
      if (c == 3) bus1.p1_req = 0;
    end
    check_val("wr p1_rdata", 32'(bus1.p1_rdata), 32'h1234);
    bus1.p1_we = 0;

    // Both requests held: last grant was p1, so p0, p1, p0, p1.
    bus1.mem_rvalue = 16'h0;
    bus1.p0_we = 0; bus1.p0_addr = 8'h40;
    bus1.p1_we = 0; bus1.p1_addr = 8'h41;
    bus1.p0_req = 1; bus1.p1_req = 1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      check_val($sformatf("tie c%0d grant", c), 32'(bus1.grant), 32'(gtab[c-1]));
      check_val($sformatf("tie c%0d p0_ack", c), 32'(bus1.p0_ack), (c == 3 || c == 11) ? 1 : 0);
      check_val($sformatf("tie c%0d p1_ack", c), 32'(bus1.p1_ack), (c == 7 || c == 15) ? 1 : 0);
      if (c == 15) begin
        bus1.p0_req = 0; bus1.p1_req = 0;
      end
    end

    // Reset in cycle 1 of a p0 write: outputs clear without a clock edge.
    bus1.p0_we = 1; bus1.p0_addr = 8'h22; bus1.p0_wdata = 16'h7777; bus1.p0_req = 1;
    tick();
    check_val("abort c1 grant", 32'(bus1.grant), 1);
    #1 reset = 1;
    #1;
    check_val("abort busy", 32'(bus1.busy), 0);
    check_val("abort grant", 32'(bus1.grant), 0);
    check_val("abort wen", 32'(bus1.mem_wenable), 0);
    check_val("abort mem_addr", 32'(bus1.mem_addr), 0);
    check_val("abort mem_wvalue", 32'(bus1.mem_wvalue), 0);
    bus1.p0_req = 0; bus1.p0_we = 0;
    tick();
    reset = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_val($sformatf("abort no ack c%0d", c), 32'(bus1.p0_ack), 0);
    end

    // Fresh p0 read after the abort.
    bus1.mem_rvalue = 16'hCAFE;
    bus1.p0_addr = 8'h13; bus1.p0_req = 1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_val($sformatf("post c%0d p0_ack", c), 32'(bus1.p0_ack), (c == 3) ? 1 : 0);
    end
    check_val("post p0_rdata", 32'(bus1.p0_rdata), 32'hCAFE);
    bus1.p0_req = 0;
    tick();

    // WAIT_STATES = 0: ack in cycle 2.
    bus0.mem_rvalue = 16'h0A0A;
    bus0.p0_addr = 8'h05; bus0.p0_req = 1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_val($sformatf("ws0 c%0d p0_ack", c), 32'(bus0.p0_ack), (c == 2) ? 1 : 0);
      check_val($sformatf("ws0 c%0d busy", c), 32'(bus0.busy), (c <= 2) ? 1 : 0);
      if (c == 2) begin
        check_val("ws0 p0_rdata", 32'(bus0.p0_rdata), 32'h0A0A);
        bus0.p0_req = 0;
      end
    end

    // WAIT_STATES = 15: ack in cycle 17.
    bus15.mem_rvalue = 16'hF00D;
    bus15.p1_addr = 8'h7F; bus15.p1_req = 1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      check_val($sformatf("ws15 c%0d p1_ack", c), 32'(bus15.p1_ack), (c == 17) ? 1 : 0);
      check_val($sformatf("ws15 c%0d busy", c), 32'(bus15.busy), (c <= 17) ? 1 : 0);
      if (c == 17) begin
        check_val("ws15 p1_rdata", 32'(bus15.p1_rdata), 32'hF00D);
        bus15.p1_req = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
